stream_demux_1to2: RTL
======================

STREAM_DEMUX_1TO2 -- requirements
Module: stream_demux_1to2

Interface
REQ-001 Parameter: WIDTH, default 8, data beat width in bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 I  input  WIDTH  input data beat.
REQ-005 in_last  input  1  marks final beat of a packet.
REQ-006 in_valid  input  1  input beat present.
REQ-007 in_ready  output  1  block accepts beat this cycle.
REQ-008 selection  input  1  destination of next packet: 0 = channel 0, 1 = channel 1.
REQ-009 Y0, Y1  output  WIDTH each  channel 0/1 output data.
REQ-010 y0_last, y1_last  output  1 each  channel 0/1 last-beat flag.
REQ-011 y0_valid, y1_valid  output  1 each  channel 0/1 beat present.
REQ-012 y0_ready, y1_ready  input  1 each  channel 0/1 downstream accepts.
REQ-013 beats0, beats1  output  16 each  accepted-beat count per channel.

Function
REQ-014 Transfer on any port SHALL occur only in a cycle where its valid and ready are both high.
REQ-015 Each channel SHALL own one output register (data, last, valid); Y/last/valid driven directly from it.
REQ-016 FSM states: IDLE, LOCK0, LOCK1.
REQ-017 Target channel: IDLE -> selection (sampled live); LOCK0 -> 0; LOCK1 -> 1.
REQ-018 in_ready SHALL be combinational: target register empty, or target register valid and its ready high this cycle.
REQ-019 On input transfer, target register SHALL load I and in_last and set valid on the next edge (1-cycle latency).
REQ-020 Channel register valid SHALL clear after its output transfer unless reloaded in the same cycle; simultaneous drain+load keeps valid high with new beat.
REQ-021 While valid high and ready low, Y/last SHALL hold stable.
REQ-022 IDLE + transfer with in_last=0 -> LOCKsel; IDLE + transfer with in_last=1 -> stay IDLE (single-beat packet).
REQ-023 LOCKx + transfer with in_last=1 -> IDLE; otherwise stay LOCKx.
REQ-024 selection changes while in LOCKx SHALL be ignored; no packet is ever split across channels.
REQ-025 Non-target channel SHALL continue draining its register independently.
REQ-026 in_valid low or no transfer SHALL leave FSM state unchanged.
REQ-027 beatsX SHALL increment by 1 per input transfer routed to channel X; wraps 16'hFFFF -> 16'h0000.
REQ-028 No beat SHALL be dropped or duplicated; per-channel order equals input order.
REQ-029 in_ready may depend on yX_ready combinationally; no combinational path from in_valid to in_ready.

Reset
REQ-030 On reset high at a clk edge: FSM -> IDLE, y0_valid=y1_valid=0, Y0=Y1=0, y0_last=y1_last=0, beats0=beats1=0.
REQ-031 Reset SHALL take priority over any concurrent transfer; buffered beats and partial packets are discarded.
REQ-032 in_ready SHALL be low during reset cycles.

Verification
REQ-033 selection=0, 3-beat packet 0x11,0x22,0x33(last), y0_ready=1 -> Y0 shows 0x11,0x22,0x33 on consecutive cycles, 1 cycle after accept; y1_valid stays 0; beats0=3.
REQ-034 Packet to ch1 started with selection=1, selection toggled to 0 mid-packet -> all beats on Y1; next packet goes to ch0.
REQ-035 y1_ready=0 with ch1 register full -> in_ready=0 for ch1 target, Y1 held stable; raise y1_ready -> transfer resumes with no loss, no duplicate.
REQ-036 Back-to-back single-beat packets alternating selection 0,1,0,1 with both readies=1 -> one beat per cycle, alternating channels, FSM stays IDLE.
REQ-037 reset asserted mid-packet with y0_valid=1 -> next cycle y0_valid=0, beats0=0, FSM IDLE; following packet routed per current selection.
REQ-038 Preload beats0=16'hFFFE via 3 transfers to ch0 -> beats0 reads FFFF then 0000 then 0001.

Source files
------------

// File: rtl/stream_demux_1to2.sv
// -----------------------------------------------------------------------------
// stream_demux_1to2
//
// Packet-aware 1-to-2 stream demultiplexer with valid/ready handshaking.
//
// Routing rules:
//   - The destination of a packet is taken from `selection` on its first beat.
//   - The channel is then locked until the beat carrying in_last is accepted,
//     so a packet is never split across channels.
//
// Buffering:
//   - Each output channel has a single register (data, last, valid).
//   - The Y/last/valid outputs are driven straight from that register.
//   - Accepted beats appear on the chosen channel one cycle after acceptance.
//   - Each channel drains on its own, even while the input is routed to the
//     other channel.
//
// Ports:
//   clk                 rising-edge clock
//   reset               synchronous, active-high reset
//   I [WIDTH-1:0]       input beat data
//   in_last             input beat is the last of its packet
//   in_valid            input beat present
//   in_ready            block accepts the input beat this cycle
//   selection           destination of the next packet (0 = ch0, 1 = ch1)
//   Y0/Y1 [WIDTH-1:0]   channel output data
//   y0_last/y1_last     channel output last-beat flag
//   y0_valid/y1_valid   channel output beat present
//   y0_ready/y1_ready   channel downstream accepts
//   beats0/beats1       16-bit wrapping count of beats routed to each channel
// -----------------------------------------------------------------------------
module stream_demux_1to2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,

    input  logic [WIDTH-1:0] I,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             selection,

    output logic [WIDTH-1:0] Y0,
    output logic             y0_last,
    output logic             y0_valid,
    input  logic             y0_ready,

    output logic [WIDTH-1:0] Y1,
    output logic             y1_last,
    output logic             y1_valid,
    input  logic             y1_ready,

    output logic [15:0]      beats0,
    output logic [15:0]      beats1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t state;

    logic target;     // channel the current/next input beat goes to
    logic tgt_free;   // target register can take a beat this cycle
    logic drain0;
    logic drain1;
    logic accept;
    logic load0;
    logic load1;

    // Target selection.
    //   - Live `selection` is used only between packets.
    //   - Inside a packet the locked channel wins.
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        target = selection;
        case (state)
            IDLE:    target = selection;
            LOCK0:   target = 1'b0;
            LOCK1:   target = 1'b1;
            default: target = selection;
        endcase
    end

    assign drain0 = y0_valid & y0_ready;
    assign drain1 = y1_valid & y1_ready;

    // A full register can still take a beat if it is emptying this cycle.
    // Only downstream ready and register state feed in_ready; in_valid
    // never does.
    assign tgt_free = target ? (~y1_valid | y1_ready)
                             : (~y0_valid | y0_ready);

    assign in_ready = ~reset & tgt_free;
    assign accept   = in_valid & in_ready;
    assign load0    = accept & ~target;
    assign load1    = accept &  target;

    // FSM, channel registers and beat counters share one clocked block.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            Y0       <= '0;
            y0_last  <= 1'b0;
            y0_valid <= 1'b0;
            Y1       <= '0;
            y1_last  <= 1'b0;
            y1_valid <= 1'b0;
            beats0   <= 16'd0;
            beats1   <= 16'd0;
        end else begin
            // Packet framing: lock on a non-last first beat,
            // release on the last beat.
            if (accept) begin
                if (in_last) begin
                    state <= IDLE;
                end else begin
                    state <= target ? LOCK1 : LOCK0;
                end
            end

            // Channel 0.
            // A load takes priority over a drain, so a same-cycle
            // drain+load keeps valid high with the new beat.
            if (load0) begin
                Y0       <= I;
                y0_last  <= in_last;
                y0_valid <= 1'b1;
                beats0   <= beats0 + 16'd1;
            end else if (drain0) begin
                y0_valid <= 1'b0;
            end

            // Channel 1.
            if (load1) begin
                Y1       <= I;
                y1_last  <= in_last;
                y1_valid <= 1'b1;
                beats1   <= beats1 + 16'd1;
            end else if (drain1) begin
                y1_valid <= 1'b0;
            end
        end
    end

endmodule
